// File: rtl/ram_fifo_controller.sv
// FIFO controller driving an external RAM with registered (1-cycle) reads.
// Tracks pointers and level; supports any DEPTH >= 2.
module ram_fifo_controller #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int LEVEL_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     write_enable,
  input  logic [WIDTH-1:0]         write_data,
  output logic                     full,
  input  logic                     read_enable,
  output logic [WIDTH-1:0]         read_data,
  output logic                     read_valid,
  output logic                     empty,
  output logic [LEVEL_WIDTH-1:0]   level,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     ram_write_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_write_address,
  output logic [WIDTH-1:0]         ram_write_data,
  output logic                     ram_read_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_read_address,
  input  logic [WIDTH-1:0]         ram_read_data
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST =
    ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [LEVEL_WIDTH-1:0] FULL_LVL =
    LEVEL_WIDTH'(DEPTH);

  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEVEL_WIDTH-1:0]   level_q, level_d;
  logic                     read_valid_q;
  logic                     overflow_q, underflow_q;
  logic                     push_ok, pop_ok;

  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LVL);

  // Reset gates both strobes so no RAM access leaks out during reset.
  assign push_ok = write_enable & ~full & ~reset;
  assign pop_ok  = read_enable & ~empty & ~reset;

  assign ram_write_enable  = push_ok;
  assign ram_write_address = wr_ptr_q;
  assign ram_write_data    = write_data;
  assign ram_read_enable   = pop_ok;
  assign ram_read_address  = rd_ptr_q;

  assign read_data  = ram_read_data;
  assign read_valid = read_valid_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      read_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      read_valid_q <= pop_ok;
      overflow_q   <= write_enable & full;
      underflow_q  <= read_enable & empty;
    end
  end

endmodule
